// File: rtl/dump_sample_corrector_if.sv
// Handshake bundle between the dump state machine / SPI readback, the corrector and the UART TX.
// The producer side (dump SM, SPI, RAM, UART status) uses master; the corrector uses slave.
interface dump_sample_corrector_if;
  logic        flopGain;
  logic        flopOffset;
  logic [15:0] spi_rd_data;
  logic        startUARTresp;
  logic [7:0]  ram_data;
  logic        tx_rdy;
  logic        trmt;
  logic [7:0]  tx_data;
  logic        busy;
  logic        ovr;

  modport master (
    output flopGain, flopOffset, spi_rd_data, startUARTresp, ram_data, tx_rdy,
    input  trmt, tx_data, busy, ovr
  );

  modport slave (
    input  flopGain, flopOffset, spi_rd_data, startUARTresp, ram_data, tx_rdy,
    output trmt, tx_data, busy, ovr
  );
endinterface

// File: rtl/dump_sample_corrector.sv
// Applies EEPROM gain/offset to each dumped RAM sample: sat_u8(((raw + offset) * gain) >>> GAIN_SHIFT).
// Optional saturation-event counter enabled by defining SAT_CNT_EN.
module dump_sample_corrector #(
  parameter int GAIN_SHIFT = 7,
  parameter int SAT_CNT_W  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  dump_sample_corrector_if.slave bus
`ifdef SAT_CNT_EN
  ,
  output logic [SAT_CNT_W-1:0]  sat_cnt
`endif
);

  typedef enum logic [2:0] {IDLE, SUM, MUL, SAT, SEND} state_e;

  state_e             state_q, state_d;
  logic [7:0]         gain_q, gain_d;
  logic [7:0]         offset_q, offset_d;
  logic [7:0]         raw_q, raw_d;
  logic signed [9:0]  sum_q, sum_d;
  logic [7:0]         gain_use_q, gain_use_d;
  logic signed [18:0] prod_q, prod_d;
  logic [7:0]         result_q, result_d;
  logic [7:0]         tx_data_q, tx_data_d;
  logic               trmt_q, trmt_d;
  logic               busy_q, busy_d;
  logic               ovr_q, ovr_d;
`ifdef SAT_CNT_EN
  logic [SAT_CNT_W-1:0] sat_cnt_q, sat_cnt_d;
`endif

  logic signed [18:0] shifted;
  logic signed [18:0] sum_ext;
  logic signed [18:0] gain_ext;
  logic               clamp_lo;
  logic               clamp_hi;
  logic [7:0]         clamped;
  logic               unused_spi_hi;

  assign unused_spi_hi = ^bus.spi_rd_data[15:8];

  assign shifted  = prod_q >>> GAIN_SHIFT;
  assign clamp_lo = shifted < 19'sd0;
  assign clamp_hi = shifted > 19'sd255;
  assign clamped  = clamp_lo ? 8'h00 : (clamp_hi ? 8'hFF : shifted[7:0]);
  assign sum_ext  = {{9{sum_q[9]}}, sum_q};
  assign gain_ext = {11'b0, gain_use_q};

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    state_d    = state_q;
    gain_d     = gain_q;
    offset_d   = offset_q;
    raw_d      = raw_q;
    sum_d      = sum_q;
    gain_use_d = gain_use_q;
    prod_d     = prod_q;
    result_d   = result_q;
    tx_data_d  = tx_data_q;
    trmt_d     = 1'b0;
    ovr_d      = 1'b0;
`ifdef SAT_CNT_EN
    sat_cnt_d  = sat_cnt_q;
`endif

    if (bus.flopGain)   gain_d   = bus.spi_rd_data[7:0];
    if (bus.flopOffset) offset_d = bus.spi_rd_data[7:0];

    // Gain is snapshotted in SUM so a mid-flight reload only affects later samples.
    unique case (state_q)
      IDLE: if (bus.startUARTresp) begin
        raw_d   = bus.ram_data;
        state_d = SUM;
      end
      SUM: begin
        sum_d      = $signed({2'b00, raw_q}) + $signed({{2{offset_q[7]}}, offset_q});
        gain_use_d = gain_q;
        state_d    = MUL;
      end
      MUL: begin
        prod_d  = sum_ext * gain_ext;
        state_d = SAT;
      end
      SAT: begin
        result_d = clamped;
`ifdef SAT_CNT_EN
        if ((clamp_lo || clamp_hi) && !(&sat_cnt_q)) sat_cnt_d = sat_cnt_q + 1'b1;
`endif
        // An idle UART lets trmt fire on SEND entry, giving the four-cycle latency.
        if (bus.tx_rdy) begin
          trmt_d    = 1'b1;
          tx_data_d = clamped;
        end
        state_d = SEND;
      end
      SEND: begin
        if (trmt_q) begin
          state_d = IDLE;
        end else if (bus.tx_rdy) begin
          trmt_d    = 1'b1;
          tx_data_d = result_q;
        end
      end
      default: state_d = IDLE;
    endcase

    if (bus.startUARTresp && (state_q != IDLE)) ovr_d = 1'b1;
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    if (rst) begin
      state_q    <= IDLE;
      gain_q     <= 8'h80;
      offset_q   <= 8'h00;
      raw_q      <= 8'h00;
      sum_q      <= '0;
      gain_use_q <= 8'h00;
      prod_q     <= '0;
      result_q   <= 8'h00;
      tx_data_q  <= 8'h00;
      trmt_q     <= 1'b0;
      busy_q     <= 1'b0;
      ovr_q      <= 1'b0;
`ifdef SAT_CNT_EN
      sat_cnt_q  <= '0;
`endif
    end else begin
      state_q    <= state_d;
      gain_q     <= gain_d;
      offset_q   <= offset_d;
      raw_q      <= raw_d;
      sum_q      <= sum_d;
      gain_use_q <= gain_use_d;
      prod_q     <= prod_d;
      result_q   <= result_d;
      tx_data_q  <= tx_data_d;
      trmt_q     <= trmt_d;
      busy_q     <= busy_d;
      ovr_q      <= ovr_d;
`ifdef SAT_CNT_EN
      sat_cnt_q  <= sat_cnt_d;
`endif
    end
  end

  assign bus.trmt    = trmt_q;
  assign bus.tx_data = tx_data_q;
  assign bus.busy    = busy_q;
  assign bus.ovr     = ovr_q;
`ifdef SAT_CNT_EN
  assign sat_cnt     = sat_cnt_q;
`endif

endmodule
